// File: rtl/logic_shift_cout_unit.sv
// logic_shift_cout_unit
//   Logic and shift/rotate group of the ALU. Logic ops finish one cycle after
//   start; shift and rotate ops step one bit per clock through a carry
//   register, so they take n extra cycles. Results and flags are registered
//   and held until the next done pulse.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   start   : operation request, sampled only while busy=0
//   opsel   : 000 AND, 001 OR, 010 XOR, 011 NOT, 100 LSR, 101 LSL, 110 RLC, 111 illegal
//   op1     : first operand (also the shift/rotate source)
//   op2     : second operand (logic ops only)
//   shamt   : shift/rotate count
//   cin     : initial carry for shift/rotate ops
//   busy    : high from the cycle after an accepted start through the done cycle
//   done    : one-cycle pulse, result/flags valid from this cycle
//   result  : operation result
//   cout    : carry-out (final carry for shift/rotate, 0 otherwise)
//   zero    : result == 0
//   neg     : result MSB
//   illegal : opsel was 111
module logic_shift_cout_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         opsel,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               zero,
    output logic               neg,
    output logic               illegal
);

    // The counter must hold both the raw shamt (RLC is unclamped) and WIDTH.
    localparam int CNT_W = (SHAMT_W > $clog2(WIDTH + 1)) ? SHAMT_W : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         op;
    logic [WIDTH-1:0]   data;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   shamt_ext;
    logic [CNT_W-1:0]   n_eff;
    logic [WIDTH:0]     step;
    logic               load_out;
    logic [WIDTH-1:0]   fin_data;
    logic               fin_carry;
    logic               fin_ill;

    // One shift/rotate step; returns {carry, data}.
    function automatic logic [WIDTH:0] shift_step(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic c);
        case (o)
            3'b100:  return {d[0], 1'b0, d[WIDTH-1:1]};
            3'b101:  return {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            3'b110:  return {d, c};   // rotate the WIDTH+1-bit ring {carry, data}
            default: return {c, d};
        endcase
    endfunction

    // Zero-step result: logic ops, illegal, and shifts with n=0 (pass op1).
    function automatic logic [WIDTH-1:0] logic_result(input logic [2:0] o,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        case (o)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~a;
            3'b111:  return '0;
            default: return a;
        endcase
    endfunction

    assign shamt_ext = CNT_W'(shamt);
    assign busy      = (state != IDLE);
    assign step      = shift_step(op, data, carry);

    always_comb begin
        n_eff = '0;
        case (opsel)
            3'b100, 3'b101: n_eff = (shamt_ext > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt_ext;
            3'b110:         n_eff = shamt_ext;
            default:        n_eff = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        fin_data  = data;
        fin_carry = carry;
        fin_ill   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_eff == '0) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                        fin_data  = logic_result(opsel, op1, op2);
                        fin_carry = opsel[2] & ~(opsel[1] & opsel[0]) & cin;
                        fin_ill   = (opsel == 3'b111);
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    load_out  = 1'b1;
                    fin_data  = step[WIDTH-1:0];
                    fin_carry = step[WIDTH];
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= load_out;
            if (load_out) begin
                result  <= fin_data;
                cout    <= fin_carry;
                zero    <= (fin_data == '0);
                neg     <= fin_data[WIDTH-1];
                illegal <= fin_ill;
            end
            if (state == IDLE && start)
                cnt <= n_eff;
            else if (state == RUN)
                cnt <= cnt - CNT_W'(1);
        end
    end

    // Working datapath: operands captured at accept, stepped while running
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op    <= opsel;
            data  <= op1;
            carry <= cin;
        end else if (state == RUN) begin
            data  <= step[WIDTH-1:0];
            carry <= step[WIDTH];
        end
    end

endmodule

// File: tb/tb_logic_shift_cout_unit.sv
module tb_logic_shift_cout_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] opsel;
    logic [7:0] op1, op2;
    logic [3:0] shamt;
    logic       cin;
    logic       busy, done, cout, zero, neg, illegal;
    logic [7:0] result;

    int n_cmp = 0;
    int n_err = 0;

    logic_shift_cout_unit #(.WIDTH(8), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opsel(opsel), .op1(op1), .op2(op2),
        .shamt(shamt), .cin(cin), .busy(busy), .done(done), .result(result),
        .cout(cout), .zero(zero), .neg(neg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] opsel;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [3:0] shamt;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Assumes the caller sits #1 after a rising edge.
    task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sh, input logic c);
        opsel = s; op1 = a; op2 = b; shamt = sh; cin = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        issue(v.opsel, v.op1, v.op2, v.shamt, v.cin);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, v.lat);
        chk({tag, ".busy_at_done"}, busy, 1'b1);
        chk({tag, ".result"}, result, v.res);
        chk({tag, ".cout"}, cout, v.cout);
        chk({tag, ".zero"}, zero, (v.res == 8'h00));
        chk({tag, ".neg"}, neg, v.res[7]);
        chk({tag, ".illegal"}, illegal, v.ill);
        @(posedge clk); #1;
        chk({tag, ".done_pulse_end"}, done, 1'b0);
        chk({tag, ".idle_after"}, busy, 1'b0);
    endtask

    initial begin
        //        opsel   op1    op2    sh    cin   res    cout  ill  lat
        vecs[0]  = '{3'b000, 8'hF0, 8'h3C, 4'd0,  1'b0, 8'h30, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'b001, 8'h0F, 8'h30, 4'd3,  1'b1, 8'h3F, 1'b0, 1'b0, 1};
        vecs[2]  = '{3'b010, 8'hFF, 8'hFF, 4'd0,  1'b0, 8'h00, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'b011, 8'h5A, 8'h00, 4'd0,  1'b1, 8'hA5, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'b101, 8'h81, 8'h00, 4'd1,  1'b0, 8'h02, 1'b1, 1'b0, 2};
        vecs[5]  = '{3'b101, 8'hFF, 8'h00, 4'd12, 1'b0, 8'h00, 1'b1, 1'b0, 9};
        vecs[6]  = '{3'b100, 8'h01, 8'h00, 4'd1,  1'b0, 8'h00, 1'b1, 1'b0, 2};
        vecs[7]  = '{3'b100, 8'h01, 8'h00, 4'd0,  1'b1, 8'h01, 1'b1, 1'b0, 1};
        vecs[8]  = '{3'b100, 8'hB5, 8'h00, 4'd3,  1'b1, 8'h16, 1'b1, 1'b0, 4};
        vecs[9]  = '{3'b110, 8'h80, 8'h00, 4'd1,  1'b0, 8'h00, 1'b1, 1'b0, 2};
        vecs[10] = '{3'b110, 8'h80, 8'h00, 4'd9,  1'b0, 8'h80, 1'b0, 1'b0, 10};
        vecs[11] = '{3'b110, 8'h80, 8'h00, 4'd2,  1'b1, 8'h03, 1'b0, 1'b0, 3};
        vecs[12] = '{3'b111, 8'hAA, 8'h55, 4'd4,  1'b1, 8'h00, 1'b0, 1'b1, 1};
        vecs[13] = '{3'b000, 8'hFF, 8'h0F, 4'd0,  1'b0, 8'h0F, 1'b0, 1'b0, 1};
        vecs[14] = '{3'b101, 8'h80, 8'h00, 4'd0,  1'b1, 8'h80, 1'b1, 1'b0, 1};

        rst = 1'b1; start = 1'b0; opsel = '0; op1 = '0; op2 = '0; shamt = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.flags", {result, cout, zero, neg, illegal}, 12'h000);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Second start while busy is ignored; LSL 0x0B by 5 -> 0x60, cout=1 at t+6.
        issue(3'b101, 8'h0B, 8'h00, 4'd5, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                opsel = 3'b000; op1 = 8'hFF; op2 = 8'hFF; shamt = 4'd0; cin = 1'b1;
                start = 1'b1;
            end
            if (k == 6) begin
                chk("hs.result", result, 8'h60);
                chk("hs.cout", cout, 1'b1);
            end
            chk($sformatf("hs.done_k%0d", k), done, (k == 6));
            chk($sformatf("hs.busy_k%0d", k), busy, (k <= 6));
            @(posedge clk); #1;
            if (k == 2) start = 1'b0;
        end

        // Reset mid-operation aborts with no done pulse.
        issue(3'b101, 8'h0B, 8'h00, 4'd5, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                chk("rst_mid.busy", busy, 1'b0);
                chk("rst_mid.outs", {result, cout, zero, neg, illegal}, 12'h000);
                rst = 1'b0;
            end
            chk($sformatf("rst_mid.done_k%0d", k), done, 1'b0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
